spi_ram_burst: RTL

Parametrised single-port RAM behind the SPI slave receive/transmit framing: consumes command-tagged frames from the SPI shift logic on `rx_valid`, and returns read data on `dout`/`tx_valid`. Successor of the fixed 256x8 SPI RAM: data width, address width and depth are generic. Adds out-of-range address detection and optional address auto-increment for burst transfers. Sits between the SPI slave serialiser and nothing else (leaf storage).

---
 rtl/spi_ram_burst_if.sv | 27 ++
 rtl/spi_ram_burst.sv | 120 ++++++++++++
 2 files changed

// File: rtl/spi_ram_burst_if.sv
// Frame/response bundle between the SPI slave serialiser (master side) and
// the burst RAM (slave side).
interface spi_ram_burst_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output err
    );
endinterface

// File: rtl/spi_ram_burst.sv
// Parametrised single-port RAM fed by command-tagged SPI frames, with address
// range checking; define SPI_RAM_AUTOINC_EN for burst address auto-increment.
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_burst_if.slave bus
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int                 IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [DATA_W-1:0]    mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [DATA_W-1:0]    dout_q;
    logic                 tx_valid_q;
    logic                 err_q;

    cmd_t                 cmd;
    logic [DATA_W-1:0]    payload;
    logic [ADDR_SIZE-1:0] addr_field;
    logic                 addr_ok;

    logic                 load_wr;
    logic                 load_rd;
    logic                 do_write;
    logic                 do_read;
    logic                 addr_reject;

    assign cmd        = cmd_t'(bus.din[DATA_W+1:DATA_W]);
    assign payload    = bus.din[DATA_W-1:0];
    assign addr_field = bus.din[ADDR_SIZE-1:0];
    assign addr_ok    = ({1'b0, addr_field} < DEPTH_LIM);

    function automatic logic [ADDR_SIZE-1:0] advance(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    always_comb begin
        load_wr     = 1'b0;
        load_rd     = 1'b0;
        do_write    = 1'b0;
        do_read     = 1'b0;
        addr_reject = 1'b0;
        if (bus.rx_valid) begin
            unique case (cmd)
                CMD_WR_ADDR: begin
                    load_wr     = addr_ok;
                    addr_reject = !addr_ok;
                end
                CMD_WR_DATA: do_write = 1'b1;
                CMD_RD_ADDR: begin
                    load_rd     = addr_ok;
                    addr_reject = !addr_ok;
                end
                CMD_RD_DATA: do_read = 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_addr[IDX_W-1:0]] <= payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_valid_q <= do_read;
            err_q      <= addr_reject;

            if (load_wr) begin
                wr_addr <= addr_field;
            end else if (do_write && AUTOINC) begin
                wr_addr <= advance(wr_addr);
            end

            if (load_rd) begin
                rd_addr <= addr_field;
            end else if (do_read && AUTOINC) begin
                rd_addr <= advance(rd_addr);
            end

            if (do_read) begin
                dout_q <= mem[rd_addr[IDX_W-1:0]];
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;

endmodule
